ahb_lite_mem_slave: RTL and testbench

//  AHB-Lite responder at the far end of the master-side generator/driver path.

---
 rtl/ahb_lite_mem_slave_pkg.sv | 60 ++++++
 rtl/ahb_lite_mem_slave_byte_ram.sv | 37 +++
 rtl/ahb_lite_mem_slave.sv | 173 +++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_mem_slave_pkg.sv
// ahb_lite_mem_slave_pkg
// Shared definitions for the AHB-Lite memory responder:
//   Trans_t      - HTRANS encodings (IDLE / BUSY / NONSEQ / SEQ)
//   Response_t   - HRESP encodings (OKAY / ERROR)
//   Slv_state_t  - responder data-phase state machine
//   SZ_*         - HSIZE encodings supported by the memory
//   isLegalXfer  - size/alignment legality of an address phase
//   laneMask     - byte lanes touched by a legal transfer
package ahb_lite_mem_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Trans_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } Slv_state_t;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    // A transfer is legal only for byte/half/word sizes that are naturally
    // aligned; anything wider than a word cannot be served by this memory.
    function automatic logic isLegalXfer(input logic [2:0] size, input logic [1:0] addrLow);
        logic legal;
        case (size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~addrLow[0];
            SZ_WORD: legal = (addrLow == 2'b00);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Little-endian lane selection: byte address a lives on lane a%4.
    function automatic logic [3:0] laneMask(input logic [2:0] size, input logic [1:0] addrLow);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addrLow;
            SZ_HALF: mask = addrLow[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_byte_ram.sv
// ahb_slave_byte_ram
// Byte-organised storage with a four-lane synchronous write port and a
// combinational 32-bit word read port sharing one word address.
// Contents are never reset.
// Ports:
//   i_clk       clock, writes happen on its rising edge
//   i_laneWe    per-lane write enables, lane k = byte (word*4 + k)
//   i_wordAddr  word index (byte address with bits [1:0] dropped)
//   i_wdata     write data, lane k on bits [8k +: 8]
//   o_rdata     {mem[A+3], mem[A+2], mem[A+1], mem[A]} for word A
module ahb_slave_byte_ram #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 8
) (
    input  logic                       i_clk,
    input  logic [3:0]                 i_laneWe,
    input  logic [ADDRWIDTH-3:0]       i_wordAddr,
    input  logic [4*DATAWIDTH-1:0]     i_wdata,
    output logic [4*DATAWIDTH-1:0]     o_rdata
);

    logic [DATAWIDTH-1:0] r_mem [0:(1 << ADDRWIDTH)-1];

    // Each enabled lane stores its own byte of the write bus; lanes that are
    // not enabled keep their previous contents.
    always_ff @(posedge i_clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (i_laneWe[lane]) begin
                r_mem[{i_wordAddr, 2'(lane)}] <= i_wdata[DATAWIDTH*lane +: DATAWIDTH];
            end
        end
    end

    assign o_rdata = {r_mem[{i_wordAddr, 2'd3}], r_mem[{i_wordAddr, 2'd2}],
                      r_mem[{i_wordAddr, 2'd1}], r_mem[{i_wordAddr, 2'd0}]};

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave
// AHB-Lite responder backed by a byte-addressable memory of
// 2**SLAVE_ADDRWIDTH bytes on a 32-bit bus. Illegal sizes and misaligned
// addresses get the two-cycle ERROR response and never touch memory.
// Optional feature macro: AHB_SLV_WAIT_EN -- when defined, every legal
// transfer is stretched by WAIT_CYCLES cycles of HREADYOUT=0 before its
// ACCESS cycle; when undefined all OKAY transfers are zero-wait.
// Ports:
//   HCLK, HRESET           clock and synchronous active-high reset
//   HSEL, HREADY           decoder select and bus-level ready
//   HADDR, HWRITE, HSIZE   address-phase control (HBURST is ignored)
//   HBURST, HTRANS         burst type (unused) and transfer type
//   HWDATA                 write data, data phase
//   HRDATA                 read data, non-zero only in ACCESS
//   HREADYOUT, HRESP       responder ready and OKAY/ERROR response
module ahb_lite_mem_slave
    import ahb_lite_mem_slave_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int ADDRWIDTH       = 32,
    parameter int SLAVE_ADDRWIDTH = 8,
    parameter int SLAVE_DATAWIDTH = 8,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [1:0]           HTRANS,
    input  logic                 HREADY,
    input  logic [DATAWIDTH-1:0] HWDATA,
    output logic [DATAWIDTH-1:0] HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP
);

    Slv_state_t                 r_state;
    Slv_state_t                 w_nextState;
    Slv_state_t                 w_okState;
    logic [SLAVE_ADDRWIDTH-1:0] r_addr;
    logic                       r_write;
    logic [2:0]                 r_size;
    logic                       w_transActive;
    logic                       w_canAccept;
    logic                       w_accept;
    logic                       w_legal;
    logic [3:0]                 w_laneWe;
    logic [DATAWIDTH-1:0]       w_ramRdata;
    logic                       w_unused;

    // Burst type and the address bits above the memory window play no part;
    // this sink keeps them visibly consumed.
    assign w_unused = ^{HBURST, HADDR[ADDRWIDTH-1:SLAVE_ADDRWIDTH], 1'(WAIT_CYCLES)};

    // Only states that drive HREADYOUT=1 can end a data phase, so only they
    // may take a new address phase even if HREADY is misdriven.
    assign w_transActive = (HTRANS == NONSEQ) || (HTRANS == SEQ);
    assign w_canAccept   = (r_state == S_IDLE) || (r_state == S_ACCESS) || (r_state == S_ERR2);
    assign w_accept      = HSEL && HREADY && w_transActive && w_canAccept;
    assign w_legal       = isLegalXfer(HSIZE, HADDR[1:0]);

`ifdef AHB_SLV_WAIT_EN
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WCW-1:0] r_waitCount;

    assign w_okState = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

    // The counter is loaded with WAIT_CYCLES-1 on acceptance so that the WAIT
    // state lasts exactly WAIT_CYCLES cycles, leaving on the cycle it reads 0.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_waitCount <= '0;
        end else if (w_accept && w_legal) begin
            r_waitCount <= WCW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
        end else if ((r_state == S_WAIT) && (r_waitCount != '0)) begin
            r_waitCount <= r_waitCount - WCW'(1);
        end
    end
`else
    assign w_okState = S_ACCESS;
`endif

    // State register plus the captured address phase. The captured fields
    // only change on acceptance so they stay stable through wait and error
    // cycles of the transfer being served.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= SZ_BYTE;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_addr  <= HADDR[SLAVE_ADDRWIDTH-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    // Next-state logic. IDLE, ACCESS and ERR2 all end a data phase with
    // HREADYOUT=1, so they share the same acceptance behaviour.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_ACCESS, S_ERR2: begin
                if (w_accept) begin
                    w_nextState = w_legal ? w_okState : S_ERR1;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                if (r_waitCount == '0) begin
                    w_nextState = S_ACCESS;
                end
            end
`endif
            S_ERR1:  w_nextState = S_ERR2;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output decode. A write commits on the edge that closes ACCESS; holding
    // the lane enables off during reset drops a write caught by reset.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = OKAY;
        HRDATA    = '0;
        w_laneWe  = 4'b0000;
        case (r_state)
            S_ACCESS: begin
                HRDATA = w_ramRdata;
                if (r_write && !HRESET) begin
                    w_laneWe = laneMask(r_size, r_addr[1:0]);
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = ERROR;
            end
            S_ERR2: begin
                HRESP = ERROR;
            end
`ifdef AHB_SLV_WAIT_EN
            S_WAIT: begin
                HREADYOUT = 1'b0;
            end
`endif
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    ahb_slave_byte_ram #(
        .ADDRWIDTH (SLAVE_ADDRWIDTH),
        .DATAWIDTH (SLAVE_DATAWIDTH)
    ) u_ram (
        .i_clk      (HCLK),
        .i_laneWe   (w_laneWe),
        .i_wordAddr (r_addr[SLAVE_ADDRWIDTH-1:2]),
        .i_wdata    (HWDATA),
        .o_rdata    (w_ramRdata)
    );

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave
// Drives the memory responder as a single-slave AHB-Lite bus (HREADY is the
// responder's own HREADYOUT) and checks every cycle against a transfer-level
// reference model. Build with AHB_SLV_WAIT_EN to exercise the wait states.
module tb_ahb_lite_mem_slave;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int assertCount = 0;
    int failCount   = 0;

`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    ahb_lite_mem_slave dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP)
    );

    // Reference model: a byte array plus the one transfer currently in its
    // data phase, described by how many stall cycles it still owes.
    logic [7:0] modelMem [0:255];
    bit         modelOn = 1'b0;
    bit         dpValid = 1'b0;
    bit         dpLegal = 1'b0;
    bit         dpWrite = 1'b0;
    int         dpAddr = 0;
    int         dpSize = 0;
    int         dpStallsLeft = 0;

    int          lastStalls = 0;
    logic [31:0] lastRdata = '0;
    logic        lastResp = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelWord(input int a);
        int base;
        base = ((a % 256) / 4) * 4;
        return {modelMem[base+3], modelMem[base+2], modelMem[base+1], modelMem[base]};
    endfunction

    // Errors owe one stall, legal transfers owe EXP_WAIT; read data is shown
    // only in the final cycle of a legal transfer.
    function automatic void expectedOutputs(output logic rdy, output logic resp, output logic [31:0] data);
        rdy  = 1'b1;
        resp = 1'b0;
        data = '0;
        if (dpValid) begin
            rdy  = (dpStallsLeft == 0);
            resp = !dpLegal;
            if (dpLegal && dpStallsLeft == 0) begin
                data = modelWord(dpAddr);
            end
        end
    endfunction

    // Model update at each rising edge.
    initial begin
        logic        eR;
        logic        eP;
        logic [31:0] eD;
        int          a;
        forever begin
            @(posedge HCLK);
            expectedOutputs(eR, eP, eD);
            if (HRESET) begin
                modelOn = 1'b1;
                dpValid = 1'b0;
            end else if (modelOn) begin
                if (dpValid) begin
                    if (eR) begin
                        if (dpLegal && dpWrite) begin
                            for (int b = 0; b < (1 << dpSize); b++) begin
                                a = (dpAddr + b) % 256;
                                modelMem[a] = HWDATA[8*(a%4) +: 8];
                            end
                        end
                        dpValid = 1'b0;
                    end else begin
                        dpStallsLeft--;
                    end
                end
                if (eR && HSEL && HTRANS[1]) begin
                    dpValid      = 1'b1;
                    dpAddr       = int'(HADDR[7:0]);
                    dpSize       = int'(HSIZE);
                    dpWrite      = HWRITE;
                    dpLegal      = (dpSize <= 2) && ((dpAddr % (1 << (dpSize % 4))) == 0);
                    dpStallsLeft = dpLegal ? EXP_WAIT : 1;
                end
            end
        end
    end

    // Cycle compare on the falling edge, away from state changes.
    initial begin
        logic        eR;
        logic        eP;
        logic [31:0] eD;
        forever begin
            @(negedge HCLK);
            if (modelOn) begin
                expectedOutputs(eR, eP, eD);
                checkOutput("cycHREADYOUT", 32'(HREADYOUT), 32'(eR));
                checkOutput("cycHRESP", 32'(HRESP), 32'(eP));
                checkOutput("cycHRDATA", HRDATA, eD);
            end
        end
    end

    // Presents one address phase and holds it until the bus is ready, then
    // places its write data. The outputs seen at that ready cycle belong to
    // the previous transfer's data phase and are kept in last*.
    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        int cycles;
        bit done;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = write;
        HADDR  = addr;
        HSIZE  = size;
        HBURST = 3'($urandom_range(0, 7));
        cycles = 0;
        done   = 1'b0;
        lastStalls = 0;
        while (!done) begin
            @(negedge HCLK);
            if (HREADY) begin
                done      = 1'b1;
                lastRdata = HRDATA;
                lastResp  = HRESP;
            end else begin
                lastStalls++;
            end
            cycles++;
            @(posedge HCLK);
            #1;
            if (!done && cycles >= 20) begin
                checkOutput("readyTimeout", 32'(HREADY), 32'd1);
                done = 1'b1;
            end
        end
        HWDATA = wdata;
    endtask

    task automatic idleBeat();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    initial begin
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;

        HRESET = 1'b1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
        HSIZE  = '0;
        HBURST = '0;
        HWDATA = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        @(negedge HCLK);
        checkOutput("resetHREADYOUT", 32'(HREADYOUT), 32'd1);
        checkOutput("resetHRESP", 32'(HRESP), 32'd0);
        checkOutput("resetHRDATA", HRDATA, 32'd0);
        @(posedge HCLK);
        #1;

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 2'b10, 1'b1, 32'(i * 4), 3'd2, $urandom);
        end
        idleBeat();

        $display("[TB] word write then back-to-back read");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        checkOutput("wrStalls", 32'(lastStalls), 32'(EXP_WAIT));
        idleBeat();
        checkOutput("rawRead", lastRdata, 32'hDEADBEEF);
        checkOutput("rawResp", 32'(lastResp), 32'd0);
        checkOutput("rawStalls", 32'(lastStalls), 32'(EXP_WAIT));

        $display("[TB] byte lane write");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hAA000000);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 3'd2, 32'h0);
        idleBeat();
        checkOutput("byteMerge", lastRdata, 32'hAAADBEEF);
        checkOutput("modelPin10", modelWord(32'h10), 32'hAAADBEEF);

        $display("[TB] misaligned halfword error");
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h01234567);
        applyStimulus(1'b1, 2'b10, 1'b1, 32'h21, 3'd1, 32'h12345678);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
        checkOutput("errResp", 32'(lastResp), 32'd1);
        checkOutput("errStalls", 32'(lastStalls), 32'd1);
        idleBeat();
        checkOutput("errNoWrite", lastRdata, 32'h01234567);
        checkOutput("modelPin20", modelWord(32'h20), 32'h01234567);

        $display("[TB] idle and deselected writes");
        applyStimulus(1'b1, 2'b00, 1'b1, 32'h10, 3'd2, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'h11111111);
        checkOutput("idleStalls", 32'(lastStalls), 32'd0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h22222222);
        checkOutput("deselStalls", 32'(lastStalls), 32'd0);
        checkOutput("deselResp", 32'(lastResp), 32'd0);
        idleBeat();
        checkOutput("idleNoWrite", lastRdata, 32'hAAADBEEF);

        $display("[TB] reset during the first data-phase cycle");
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = 32'h10;
        HSIZE  = 3'd2;
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("rstMidReady", 32'(HREADYOUT), 32'd1);
        checkOutput("rstMidData", HRDATA, 32'd0);
        @(posedge HCLK);
        #1;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            sel   = ($urandom_range(0, 9) != 0);
            trans = 2'($urandom_range(0, 3));
            write = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 3'd1) addr[0] = 1'b0;
                else if (size == 3'd2) addr[1:0] = 2'b00;
            end
            applyStimulus(sel, trans, write, addr, size, $urandom);
            if ($urandom_range(0, 49) == 0) begin
                HTRANS = 2'b00;
                HRESET = 1'b1;
                @(posedge HCLK);
                #1;
                HRESET = 1'b0;
            end
        end
        repeat (3) idleBeat();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
